// File: rtl/reg_file_wr_8x16.sv
// ---------------------------------------------------------------------------
// reg_file_wr_8x16
//
// LC-3 general-purpose register file: eight WIDTH-bit registers R0..R7.
// The register named by DR is loaded from the datapath bus, and two read
// ports (SR1/SR2) feed the ALU and the address adders.
//
// The write side is the inverse of the 8-way read mux. DR is decoded to a
// one-hot enable, so at most one register can load on any edge. R0 is an
// ordinary writable register and does not read back as zero.
//
// Parameters
//   WIDTH   register and data-port width
//   BYPASS  1: a same-cycle write to the register being read is forwarded
//              to that read port
//           0: the read ports always show the stored value
//
// Ports
//   Clk        in   1      rising-edge clock
//   Reset      in   1      asynchronous, active-high; clears R0..R7 and
//                          Reg_Valid
//   LD_REG     in   1      write enable for R[DR]
//   DR         in   3      destination register index
//   Data_In    in   WIDTH  write data from the datapath bus
//   SR1        in   3      read port 1 index
//   SR2        in   3      read port 2 index
//   SR1_Out    out  WIDTH  R[SR1], combinational
//   SR2_Out    out  WIDTH  R[SR2], combinational
//   Reg_Valid  out  8      sticky "written since reset" flag per register
// ---------------------------------------------------------------------------
module reg_file_wr_8x16 #(
  parameter int WIDTH  = 16,
  parameter int BYPASS = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [2:0]       DR,
  input  logic [WIDTH-1:0] Data_In,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  output logic [7:0]       Reg_Valid
);

  logic [7:0][WIDTH-1:0] regs;
  logic [7:0]            valid;
  logic [7:0]            we;

  // One-hot destination decode. A DR value that is not a clean 0..7
  // (X or Z in simulation) falls through to the default, so no register
  // loads on that edge.
  function automatic logic [7:0] decode_dr(input logic ld, input logic [2:0] idx);
    logic [7:0] oh;
    oh = '0;
    if (ld) begin
      case (idx)
        3'd0:    oh = 8'b0000_0001;
        3'd1:    oh = 8'b0000_0010;
        3'd2:    oh = 8'b0000_0100;
        3'd3:    oh = 8'b0000_1000;
        3'd4:    oh = 8'b0001_0000;
        3'd5:    oh = 8'b0010_0000;
        3'd6:    oh = 8'b0100_0000;
        3'd7:    oh = 8'b1000_0000;
        default: oh = '0;
      endcase
    end
    return oh;
  endfunction

  // Read-port selection, with optional forwarding of the write in flight.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [2:0]            idx,
    input logic [7:0][WIDTH-1:0] stored,
    input logic                  ld,
    input logic [2:0]            dst,
    input logic [WIDTH-1:0]      wdata
  );
    logic [WIDTH-1:0] val;
    val = stored[idx];
    if ((BYPASS != 0) && ld && (idx == dst))
      val = wdata;
    return val;
  endfunction

  always_comb begin
    we = decode_dr(LD_REG, DR);
  end

  // Storage stage: registers and valid flags load on the clock edge.
  // Reset is asynchronous and also clears the data, so a write that
  // coincides with Reset is discarded.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs  <= '0;
      valid <= '0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (we[n]) begin
          regs[n]  <= Data_In;
          valid[n] <= 1'b1;
        end
      end
    end
  end

  // Combinational read stage. The forwarding path does not pass through
  // the reset registers, so Reset gates both ports directly. The outputs
  // are therefore zero for the whole time Reset is high, even with BYPASS.
  always_comb begin
    SR1_Out = '0;
    SR2_Out = '0;
    if (!Reset) begin
      SR1_Out = read_port(SR1, regs, LD_REG, DR, Data_In);
      SR2_Out = read_port(SR2, regs, LD_REG, DR, Data_In);
    end
  end

  assign Reg_Valid = valid;

endmodule

// File: tb/tb_reg_file_wr_8x16.sv
module tb_reg_file_wr_8x16;

  localparam int WIDTH = 16;

  logic             Clk;
  logic             Reset;
  logic             LD_REG;
  logic [2:0]       DR;
  logic [WIDTH-1:0] Data_In;
  logic [2:0]       SR1;
  logic [2:0]       SR2;
  logic [WIDTH-1:0] sr1_out_nb, sr2_out_nb, sr1_out_bp, sr2_out_bp;
  logic [7:0]       valid_nb, valid_bp;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Two copies share all inputs: one without bypass, one with bypass.
  reg_file_wr_8x16 #(.WIDTH(WIDTH), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .Data_In(Data_In),
    .SR1(SR1), .SR2(SR2), .SR1_Out(sr1_out_nb), .SR2_Out(sr2_out_nb),
    .Reg_Valid(valid_nb)
  );

  reg_file_wr_8x16 #(.WIDTH(WIDTH), .BYPASS(1)) dut_bp (
    .Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .Data_In(Data_In),
    .SR1(SR1), .SR2(SR2), .SR1_Out(sr1_out_bp), .SR2_Out(sr2_out_bp),
    .Reg_Valid(valid_bp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Wait for a rising edge, then move 1 time unit past it before
  // driving or sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [WIDTH-1:0] val);
    LD_REG  = 1'b1;
    DR      = idx;
    Data_In = val;
    tick();
    LD_REG  = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; LD_REG = 1'b0; DR = '0; Data_In = '0; SR1 = '0; SR2 = '0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      check_cnt++;
      if (sr1_out_nb !== 16'h0000 || sr2_out_nb !== 16'h0000 ||
          sr1_out_bp !== 16'h0000 || sr2_out_bp !== 16'h0000)
        $display("FAIL reset_read idx=%0d got nb=%h/%h bp=%h/%h want 0000",
                 i, sr1_out_nb, sr2_out_nb, sr1_out_bp, sr2_out_bp);
      else pass_cnt++;
    end
    check_cnt++;
    if (valid_nb !== 8'h00 || valid_bp !== 8'h00)
      $display("FAIL reset_valid got %h/%h want 00", valid_nb, valid_bp);
    else pass_cnt++;
    // Release Reset between edges.
    #3 Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    write_reg(3'd5, 16'hBEEF);
    SR1 = 3'd5; SR2 = 3'd4;
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'hBEEF || sr1_out_bp !== 16'hBEEF)
      $display("FAIL single_sr1 got %h/%h want beef", sr1_out_nb, sr1_out_bp);
    else pass_cnt++;
    check_cnt++;
    if (sr2_out_nb !== 16'h0000 || sr2_out_bp !== 16'h0000)
      $display("FAIL single_sr2 got %h/%h want 0000", sr2_out_nb, sr2_out_bp);
    else pass_cnt++;
    check_cnt++;
    if (valid_nb !== 8'h20)
      $display("FAIL single_valid got %h want 20", valid_nb);
    else pass_cnt++;
    // Rewriting the same register keeps its flag set and loads the new value.
    write_reg(3'd5, 16'hBEEE);
    #1;
    check_cnt++;
    if (valid_nb !== 8'h20 || sr1_out_nb !== 16'hBEEE)
      $display("FAIL sticky_valid got valid=%h r5=%h want valid=20 r5=beee",
               valid_nb, sr1_out_nb);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Load R0..R7 on eight consecutive edges.
    LD_REG = 1'b1;
    for (int i = 0; i < 8; i++) begin
      DR = 3'(i);
      Data_In = 16'h1000 + 16'(i);
      tick();
    end
    LD_REG = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i); SR2 = 3'(7 - i);
      #1;
      check_cnt++;
      if (sr1_out_nb !== 16'h1000 + 16'(i) || sr2_out_nb !== 16'h1007 - 16'(i))
        $display("FAIL sweep idx=%0d got %h/%h want %h/%h", i, sr1_out_nb,
                 sr2_out_nb, 16'h1000 + 16'(i), 16'h1007 - 16'(i));
      else pass_cnt++;
    end
    check_cnt++;
    if (valid_nb !== 8'hFF || valid_bp !== 8'hFF)
      $display("FAIL fill_valid got %h/%h want ff", valid_nb, valid_bp);
    else pass_cnt++;
  endtask

  task automatic test_no_load();
    LD_REG = 1'b0; DR = 3'd2; Data_In = 16'hFFFF; SR1 = 3'd2; SR2 = 3'd2;
    tick();
    check_cnt++;
    if (sr1_out_nb !== 16'h1002 || sr2_out_bp !== 16'h1002)
      $display("FAIL no_load got %h/%h want 1002", sr1_out_nb, sr2_out_bp);
    else pass_cnt++;
    check_cnt++;
    if (valid_nb !== 8'hFF)
      $display("FAIL no_load_valid got %h want ff", valid_nb);
    else pass_cnt++;
  endtask

  task automatic test_read_during_write();
    write_reg(3'd6, 16'h0006);
    LD_REG = 1'b1; DR = 3'd6; Data_In = 16'hA5A5; SR1 = 3'd6; SR2 = 3'd3;
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'h0006)
      $display("FAIL rdw_nobypass_before got %h want 0006", sr1_out_nb);
    else pass_cnt++;
    check_cnt++;
    if (sr1_out_bp !== 16'hA5A5)
      $display("FAIL rdw_bypass_before got %h want a5a5", sr1_out_bp);
    else pass_cnt++;
    // The port not addressing DR keeps showing the stored value.
    check_cnt++;
    if (sr2_out_bp !== 16'h1003)
      $display("FAIL rdw_bypass_other got %h want 1003", sr2_out_bp);
    else pass_cnt++;
    tick();
    LD_REG = 1'b0;
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'hA5A5 || sr1_out_bp !== 16'hA5A5)
      $display("FAIL rdw_after got %h/%h want a5a5", sr1_out_nb, sr1_out_bp);
    else pass_cnt++;
    // With LD_REG low, a matching DR must not be forwarded.
    DR = 3'd6; Data_In = 16'h5555;
    #1;
    check_cnt++;
    if (sr1_out_bp !== 16'hA5A5)
      $display("FAIL bypass_ld_low got %h want a5a5", sr1_out_bp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_cycle();
    SR1 = 3'd1; SR2 = 3'd7;
    @(negedge Clk);
    LD_REG = 1'b1; DR = 3'd1; Data_In = 16'h1234;
    Reset = 1'b1;
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'h0000 || sr2_out_nb !== 16'h0000 ||
        sr1_out_bp !== 16'h0000 || sr2_out_bp !== 16'h0000)
      $display("FAIL async_reset_out got nb=%h/%h bp=%h/%h want 0000",
               sr1_out_nb, sr2_out_nb, sr1_out_bp, sr2_out_bp);
    else pass_cnt++;
    check_cnt++;
    if (valid_nb !== 8'h00)
      $display("FAIL async_reset_valid got %h want 00", valid_nb);
    else pass_cnt++;
    // Hold Reset across a rising edge while the write is still requested.
    tick();
    @(negedge Clk);
    LD_REG = 1'b0;
    Reset = 1'b0;
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'h0000 || sr2_out_nb !== 16'h0000 || valid_nb !== 8'h00)
      $display("FAIL reset_discard got r1=%h r7=%h valid=%h want 0000/0000/00",
               sr1_out_nb, sr2_out_nb, valid_nb);
    else pass_cnt++;
    // The first edge with Reset low performs the write.
    write_reg(3'd1, 16'h4321);
    #1;
    check_cnt++;
    if (sr1_out_nb !== 16'h4321 || valid_nb !== 8'h02)
      $display("FAIL post_reset_write got r1=%h valid=%h want 4321/02",
               sr1_out_nb, valid_nb);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_no_load();
    test_read_during_write();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Watchdog in case the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d checks=%0d", pass_cnt, check_cnt);
    $fatal(1);
  end

endmodule

// File: doc/reg_file_wr_8x16.md
Name: reg_file_wr_8x16

Overview:
- LC-3 general-purpose register file, write side plus two read ports.
- A 3-bit destination select (DR) is decoded one-hot to load exactly one of eight WIDTH-bit registers R0..R7 from the datapath bus.
- This is the inverse of the 8-way read-select mux.
- Sits between the datapath bus (write data) and the ALU/address adders (SR1/SR2 operands).

Parameters:
- WIDTH, 16, bit width of each register and of data ports.
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports when read index equals DR and LD_REG=1; 0 = read ports always show stored value.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high; clears all registers.
- LD_REG  input  1  write enable for the register selected by DR.
- DR  input  3  destination register index; decoded one-hot internally.
- Data_In  input  WIDTH  write data (datapath bus).
- SR1  input  3  read port 1 index.
- SR2  input  3  read port 2 index.
- SR1_Out  output  WIDTH  contents of R[SR1], combinational.
- SR2_Out  output  WIDTH  contents of R[SR2], combinational.
- Reg_Valid  output  8  per-register "written since reset" flags, bit n = Rn.

Behaviour:
- Reset is asynchronous and active-high. Asserting Reset immediately forces R0..R7 = 0 and Reg_Valid = 8'h00, independent of Clk. Consequently SR1_Out = SR2_Out = 0 while Reset is high, including with BYPASS=1; bypass is gated off by Reset.
- Write decode: an 8-bit one-hot we[n] = LD_REG & (DR == n). Exactly one bit is set when LD_REG=1; all bits are clear when LD_REG=0.
- Write timing: on a rising Clk with Reset low, R[n] <= Data_In and Reg_Valid[n] <= 1 for the single n with we[n]=1. All other registers hold. Latency is 1 cycle from LD_REG/DR/Data_In sampled to the stored value.
- LD_REG=0 at the edge: no register or Reg_Valid change, whatever DR and Data_In are.
- Read ports: pure combinational 8-to-1 selection of stored registers by SR1/SR2. No clock latency. Both ports are independent and may select the same register.
- Read-during-write, BYPASS=0: a read of R[DR] in the write cycle returns the old value; the new value appears after the edge.
- Read-during-write, BYPASS=1: when LD_REG=1 and SRx == DR, SRx_Out = Data_In in the same cycle. Otherwise SRx_Out is the stored value.
- Reg_Valid bits are sticky and are cleared only by Reset. Writing the same register repeatedly keeps its bit at 1.
- Reset and a Clk edge together: Reset wins; registers remain 0 and the write is discarded.
- Reset deasserted mid-cycle: the first write takes effect on the first rising Clk with Reset low.
- Unknown DR/SR values: outputs are unconstrained, but no more than one register may be written per edge under any DR encoding.
- No R0-hardwired-zero behaviour; R0 is an ordinary writable register (LC-3 semantics).

Test Plan:
- Reset then read all eight indices on SR1/SR2 -> both outputs 16'h0000; Reg_Valid = 8'h00.
- LD_REG=1, DR=3'b101, Data_In=16'hBEEF, one edge; SR1=5, SR2=4 -> SR1_Out=16'hBEEF, SR2_Out=16'h0000, Reg_Valid=8'h20.
- Write R0..R7 with 16'h1000+n on eight consecutive edges, then sweep SR1 0..7 -> SR1_Out = 16'h1000..16'h1007 in order; Reg_Valid=8'hFF.
- LD_REG=0, DR=2, Data_In=16'hFFFF, edge -> R2 unchanged (holds prior 16'h1002); no Reg_Valid change.
- BYPASS=0: R6=16'h0006; in the write cycle set LD_REG=1, DR=6, Data_In=16'hA5A5, SR1=6 -> SR1_Out=16'h0006 before the edge and 16'hA5A5 after. BYPASS=1: same stimulus -> SR1_Out=16'hA5A5 before the edge.
- With all registers loaded, pulse Reset high mid-cycle between edges -> SR1_Out/SR2_Out drop to 0 immediately. A write concurrent with Reset (DR=1, Data_In=16'h1234) is discarded, so R1 = 0 after Reset falls.
